merge_header_payload: RTL
=========================

MERGE_HEADER_PAYLOAD -- requirements
Module: merge_header_payload

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 64, giving the stream data width in bits.
REQ-002 The module SHALL have parameter MAX_HEADER_SIZE, default 1, giving the maximum header length in data beats.
REQ-003 The module SHALL have parameter FLUSH_CYCLES, default 16, giving the idle cycles before a held beat is flushed (used only with MERGE_FLUSH_EN).
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock.
REQ-005 The module SHALL have port reset, input, 1 bit: synchronous, active-low reset (0 = reset).
REQ-006 The module SHALL have port in, avalonST.sink, DATA_WIDTH wide: the split stream (a header packet, optionally followed by a payload packet).
REQ-007 The module SHALL have port i_payload_in, input, 1 bit, qualified by in.valid: 1 = the current in beat belongs to a payload packet.
REQ-008 The module SHALL have port out, avalonST.src, DATA_WIDTH wide: the recombined single-packet stream.
REQ-009 The module SHALL have port o_id, output, 32 bits: the internal ID of the current packet.
REQ-010 The module SHALL have port o_hdr_err, output, 1 bit: one-cycle pulse on an over-length header.
REQ-011 The module SHALL have port o_orphan, output, 1 bit: one-cycle pulse on a payload beat with no held header.

Function
REQ-012 The module SHALL implement FSM states PASS_HEAD, HOLD and PASS_PAYLOAD.
REQ-013 In PASS_HEAD, in.ready SHALL equal out.ready, and each accepted header beat without eop SHALL be forwarded unchanged in the same cycle.
REQ-014 In PASS_HEAD, on an accepted beat with in.sop=1, o_id SHALL load in.data[DATA_WIDTH-2 -: 32] on the next edge.
REQ-015 In PASS_HEAD, an accepted beat with in.eop=1 SHALL be captured into the hold register and not output (out.valid=0 that cycle), and the FSM SHALL enter HOLD.
REQ-016 In HOLD, in.ready SHALL be 0 and out.valid SHALL be 0 until in.valid=1.
REQ-017 In HOLD with in.valid=1 and i_payload_in=1, the held beat SHALL be output with eop=0; on out.ready=1 the FSM SHALL go to PASS_PAYLOAD.
REQ-018 In HOLD with in.valid=1 and i_payload_in=0, the held beat SHALL be output with eop=1; on out.ready=1 the FSM SHALL go to PASS_HEAD.
REQ-019 In HOLD, the held beat's sop, error, empty and data SHALL be output as captured, and the beat SHALL remain stable while out.ready=0.
REQ-020 In PASS_PAYLOAD, in.ready SHALL equal out.ready, and beats SHALL be forwarded with sop forced to 0; an accepted beat with eop=1 SHALL return the FSM to PASS_HEAD.
REQ-021 The module SHALL count header beats in a $clog2(MAX_HEADER_SIZE)+2 bit counter that clears on eop.
REQ-022 When an accepted header beat would exceed MAX_HEADER_SIZE without eop, o_hdr_err SHALL pulse for one cycle and the beat SHALL still be forwarded.
REQ-023 In PASS_HEAD, an accepted beat with i_payload_in=1 SHALL be forwarded with out.error=1, and o_orphan SHALL pulse for one cycle.
REQ-024 Latency SHALL be 0 cycles for pass-through beats; the held beat SHALL appear in the first cycle in which the next packet's first beat is valid.

Reset
REQ-025 While reset=0 on an edge, the FSM SHALL go to PASS_HEAD, the hold register and header counter SHALL clear, and o_id, o_hdr_err and o_orphan SHALL be 0.
REQ-026 During reset, out.valid and in.ready SHALL be 0; a reset mid-packet SHALL discard any held beat without emitting it.

Configuration
REQ-027 With MERGE_FLUSH_EN defined, after FLUSH_CYCLES consecutive HOLD cycles with in.valid=0, the held beat SHALL be output with eop=1, and on out.ready the FSM SHALL go to PASS_HEAD; any in.valid=1 SHALL reset the idle counter.
REQ-028 Without MERGE_FLUSH_EN, HOLD SHALL wait indefinitely, and no idle counter logic SHALL be synthesized.

Structure
REQ-029 The FSM state enum merge_state_t and the o_id field offset constant SHALL live in shared package pkt_parser_pkg.
REQ-030 The one-beat holding register, with load, clear and eop-override, SHALL be sub-module merge_hold_reg.

Verification
REQ-031 Merge: H0 (sop,eop, data[62:31]=0x1234_5678), then P0 (sop, payload_in=1), then P1 (eop) -> out shows H0 sop=1 eop=0, P0 sop=0, P1 eop=1; o_id=0x12345678.
REQ-032 Header-only: H0 (sop,eop), then H1 (sop,eop, payload_in=0) -> H0 is output with sop=1, eop=1 in the cycle H1 is valid, and H1 is then held.
REQ-033 Backpressure: out.ready=0 for 3 cycles while HOLD is emitting -> out.data and out.valid are stable, in.ready=0, and no beat is lost or duplicated.
REQ-034 Flush (MERGE_FLUSH_EN, FLUSH_CYCLES=4): H0 held with no input for 4 cycles -> H0 is output with eop=1 and the FSM is in PASS_HEAD.
REQ-035 Orphan payload beat in PASS_HEAD -> out.error=1 and a single o_orphan pulse; an over-length header (MAX_HEADER_SIZE=1, 2 beats with no eop) -> a single o_hdr_err pulse.
REQ-036 Reset=0 during PASS_PAYLOAD -> out.valid=0 on the next cycle, o_id=0, and the next header is handled normally.

Source files
------------

// File: rtl/pkt_parser_pkg.sv
// Shared packet-parser types: merge FSM state encoding and placement of the
// packet ID field inside a header beat.
package pkt_parser_pkg;

  typedef enum logic [1:0] {
    PASS_HEAD    = 2'd0,
    HOLD         = 2'd1,
    PASS_PAYLOAD = 2'd2
  } merge_state_t;

  // Packet ID sits just below the data MSB: data[DATA_WIDTH-ID_TOP_OFS -: ID_WIDTH]
  localparam int ID_TOP_OFS = 2;
  localparam int ID_WIDTH   = 32;

  function automatic int empty_width(input int data_width);
    return (data_width <= 8) ? 1 : $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/merge_hold_reg.sv
// One-beat holding register for the last header beat; load wins over clear,
// and the stored eop can be overridden on the way out.
module merge_hold_reg #(
  parameter int DATA_WIDTH = 64,
  parameter int EMPTY_W    = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  clear,
  input  logic                  eop_ovr,
  input  logic                  eop_val,
  input  logic [DATA_WIDTH-1:0] d_data,
  input  logic                  d_sop,
  input  logic                  d_eop,
  input  logic                  d_error,
  input  logic [EMPTY_W-1:0]    d_empty,
  output logic [DATA_WIDTH-1:0] q_data,
  output logic                  q_sop,
  output logic                  q_eop,
  output logic                  q_error,
  output logic [EMPTY_W-1:0]    q_empty
);

  logic                  eop_r;

  always_ff @(posedge clk) begin
    if (!reset || (clear && !load)) begin
      q_data  <= '0;
      q_sop   <= 1'b0;
      eop_r   <= 1'b0;
      q_error <= 1'b0;
      q_empty <= '0;
    end else if (load) begin
      q_data  <= d_data;
      q_sop   <= d_sop;
      eop_r   <= d_eop;
      q_error <= d_error;
      q_empty <= d_empty;
    end
  end

  assign q_eop = eop_ovr ? eop_val : eop_r;

endmodule

// File: rtl/merge_header_payload.sv
// Recombines a split header/payload stream into one packet by holding the
// header's last beat until the next packet shows whether a payload follows.
// Optional idle flush of the held beat: define MERGE_FLUSH_EN.
module merge_header_payload
  import pkt_parser_pkg::*;
#(
  parameter int DATA_WIDTH      = 64,
  parameter int MAX_HEADER_SIZE = 1,
  parameter int FLUSH_CYCLES    = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [DATA_WIDTH-1:0]               in_data,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic                                in_sop,
  input  logic                                in_eop,
  input  logic                                in_error,
  input  logic [empty_width(DATA_WIDTH)-1:0]  in_empty,
  input  logic                                i_payload_in,
  output logic [DATA_WIDTH-1:0]               out_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                out_sop,
  output logic                                out_eop,
  output logic                                out_error,
  output logic [empty_width(DATA_WIDTH)-1:0]  out_empty,
  output logic [31:0]                         o_id,
  output logic                                o_hdr_err,
  output logic                                o_orphan
);

  localparam int EW = empty_width(DATA_WIDTH);
  localparam int CW = $clog2(MAX_HEADER_SIZE) + 2;

  merge_state_t          state, state_d;
  logic [CW-1:0]         hdr_cnt;
  logic                  hold_load, hold_clr, hdr_acc, hdr_err_d, orphan_d, id_load, flush;
  logic [DATA_WIDTH-1:0] h_data;
  logic                  h_sop, h_eop, h_error, eop_val;
  logic [EW-1:0]         h_empty;

  merge_hold_reg #(.DATA_WIDTH(DATA_WIDTH), .EMPTY_W(EW)) u_hold (
    .clk(clk), .reset(reset), .load(hold_load), .clear(hold_clr),
    .eop_ovr(state == HOLD), .eop_val(eop_val),
    .d_data(in_data), .d_sop(in_sop), .d_eop(in_eop), .d_error(in_error), .d_empty(in_empty),
    .q_data(h_data), .q_sop(h_sop), .q_eop(h_eop), .q_error(h_error), .q_empty(h_empty)
  );

`ifdef MERGE_FLUSH_EN
  localparam int IW = $clog2(FLUSH_CYCLES + 1);
  logic [IW-1:0] idle_cnt;

  always_ff @(posedge clk) begin
    if (!reset || state != HOLD || in_valid) idle_cnt <= '0;
    else if (!flush)                         idle_cnt <= idle_cnt + 1'b1;
  end

  assign flush = (idle_cnt == IW'(FLUSH_CYCLES));
`else
  // HOLD waits for the next packet indefinitely in this build
  assign flush = (FLUSH_CYCLES < 0);
`endif

  always_comb begin
    state_d   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = in_data;
    out_sop   = in_sop;
    out_eop   = in_eop;
    out_error = in_error;
    out_empty = in_empty;
    hold_load = 1'b0;
    hold_clr  = 1'b0;
    hdr_acc   = 1'b0;
    hdr_err_d = 1'b0;
    orphan_d  = 1'b0;
    id_load   = 1'b0;
    eop_val   = in_valid ? !i_payload_in : 1'b1;
    if (reset) begin
      case (state)
        PASS_HEAD: begin
          in_ready = out_ready;
          id_load  = in_valid && out_ready && in_sop;
          if (i_payload_in) begin
            // payload with no header in front of it: flag and pass through
            out_valid = in_valid;
            out_error = 1'b1;
            orphan_d  = in_valid && out_ready;
          end else begin
            hdr_acc   = in_valid && out_ready;
            hdr_err_d = hdr_acc && !in_eop && (hdr_cnt >= CW'(MAX_HEADER_SIZE));
            out_valid = in_valid && !in_eop;
            if (hdr_acc && in_eop) begin
              hold_load = 1'b1;
              state_d   = HOLD;
            end
          end
        end
        HOLD: begin
          out_valid = in_valid || flush;
          out_data  = h_data;
          out_sop   = h_sop;
          out_eop   = h_eop;
          out_error = h_error;
          out_empty = h_empty;
          if (out_valid && out_ready) begin
            hold_clr = 1'b1;
            state_d  = (in_valid && i_payload_in) ? PASS_PAYLOAD : PASS_HEAD;
          end
        end
        PASS_PAYLOAD: begin
          in_ready  = out_ready;
          out_valid = in_valid;
          out_sop   = 1'b0;
          if (in_valid && out_ready && in_eop) state_d = PASS_HEAD;
        end
        default: state_d = PASS_HEAD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= PASS_HEAD;
      hdr_cnt   <= '0;
      o_id      <= '0;
      o_hdr_err <= 1'b0;
      o_orphan  <= 1'b0;
    end else begin
      state     <= state_d;
      o_hdr_err <= hdr_err_d;
      o_orphan  <= orphan_d;
      if (id_load) o_id <= in_data[DATA_WIDTH-ID_TOP_OFS -: ID_WIDTH];
      // saturate just past the limit so a long header cannot wrap back to legal
      if (hdr_acc) begin
        if (in_eop)                                 hdr_cnt <= '0;
        else if (hdr_cnt < CW'(MAX_HEADER_SIZE + 1)) hdr_cnt <= hdr_cnt + 1'b1;
      end
    end
  end

endmodule
